// File: rtl/mulsgn_arbiter.sv
// mulsgn_arbiter
//
// Purpose: shares one signed multiplier (registered X/Y operands in, product
// P back after a fixed latency of LAT cycles) among NREQ requesters. Each
// requester offers an operand pair with a valid/ready handshake. One winner
// per cycle is accepted, and its operands are loaded into mul_x/mul_y. The
// winner's ID travels down a tag pipe that matches the multiplier latency.
// The product and its ID are then written to a show-ahead result FIFO.
// A credit counter bounds outstanding work to the FIFO depth, so the FIFO
// can never overflow.
//
// Optional feature macro: MULSGN_ARB_RR_EN
//   defined   -> round-robin arbitration with a rotating start pointer
//   undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : [NREQ] per-requester operand valid
//   req_x      : [NREQ*widthX] packed X operands, slice i = requester i
//   req_y      : [NREQ*widthY] packed Y operands
//   req_ready  : [NREQ] one-hot-or-zero grant/accept
//   mul_x      : [widthX] registered X operand to the multiplier
//   mul_y      : [widthY] registered Y operand to the multiplier
//   mul_p      : [widthX+widthY] multiplier product (LAT cycles after mul_x/y)
//   rsp_valid  : result FIFO not empty
//   rsp_ready  : consumer accepts the head result
//   rsp_p      : [widthX+widthY] head product
//   rsp_id     : [IDW] requester index of the head product
//   busy       : any operation outstanding
module mulsgn_arbiter #(
   parameter int NREQ   = 4,
   parameter int widthX = 8,
   parameter int widthY = 8,
   parameter int LAT    = 2,
   localparam int IDW   = (NREQ <= 2) ? 1 : $clog2(NREQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*widthX-1:0]   req_x,
   input  logic [NREQ*widthY-1:0]   req_y,
   output logic [NREQ-1:0]          req_ready,
   output logic [widthX-1:0]        mul_x,
   output logic [widthY-1:0]        mul_y,
   input  logic [widthX+widthY-1:0] mul_p,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [widthX+widthY-1:0] rsp_p,
   output logic [IDW-1:0]           rsp_id,
   output logic                     busy
);

   localparam int PWID  = widthX + widthY;
   localparam int DEPTH = LAT + 3;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int AW    = $clog2(DEPTH);

   // ---------------------------------------------------------------
   // Operand slices
   // ---------------------------------------------------------------
   logic [widthX-1:0] x_slice [NREQ];
   logic [widthY-1:0] y_slice [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
         assign x_slice[gi] = req_x[gi*widthX +: widthX];
         assign y_slice[gi] = req_y[gi*widthY +: widthY];
      end
   endgenerate

   // ---------------------------------------------------------------
   // Credit counter and issue enable
   // ---------------------------------------------------------------
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic           issue_en;
   logic           accept;
   logic           pop;
   logic           push;
   logic [IDW-1:0] win_id;

   assign issue_en = (cnt_reg < CW'(DEPTH));
   // rst_n gating keeps req_ready low for the whole reset, even though the
   // credit counter alone would already permit issue.
   assign accept   = rst_n & issue_en & (|req_valid);
   assign pop      = rsp_valid & rsp_ready;

   always_comb begin
      cnt_next = cnt_reg;
      if (accept && !pop)
         cnt_next = cnt_reg + CW'(1);
      else if (!accept && pop)
         cnt_next = cnt_reg - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_next;
   end

   assign busy = (cnt_reg != '0);

   // ---------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------
`ifdef MULSGN_ARB_RR_EN
   logic [IDW-1:0] ptr_reg, ptr_next;

   // The winner is the valid requester at the smallest rotational distance
   // from the pointer (distance 0 = the pointer itself).
   always_comb begin
      int best_d;
      int d;
      win_id = '0;
      best_d = NREQ;
      for (int j = 0; j < NREQ; j++) begin
         d = j - int'(ptr_reg);
         if (d < 0)
            d = d + NREQ;
         if (req_valid[j] && (d < best_d)) begin
            best_d = d;
            win_id = IDW'(j);
         end
      end
   end

   always_comb begin
      ptr_next = ptr_reg;
      if (accept)
         ptr_next = (win_id == IDW'(NREQ-1)) ? '0 : win_id + IDW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr_reg <= '0;
      else
         ptr_reg <= ptr_next;
   end
`else
   always_comb begin
      win_id = '0;
      for (int j = NREQ-1; j >= 0; j--) begin
         if (req_valid[j])
            win_id = IDW'(j);
      end
   end
`endif

   always_comb begin
      req_ready = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (accept && (win_id == IDW'(j)))
            req_ready[j] = 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Operand registers
   // ---------------------------------------------------------------
   logic [widthX-1:0] sel_x;
   logic [widthY-1:0] sel_y;

   always_comb begin
      sel_x = '0;
      sel_y = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (win_id == IDW'(j)) begin
            sel_x = x_slice[j];
            sel_y = y_slice[j];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_x <= '0;
         mul_y <= '0;
      end else if (accept) begin
         mul_x <= sel_x;
         mul_y <= sel_y;
      end
   end

   // ---------------------------------------------------------------
   // Tag pipe: stage 0 is loaded on the accept edge, so stage LAT is
   // valid exactly in the cycle where mul_p carries that product.
   // ---------------------------------------------------------------
   logic           tag_v_reg  [LAT+1];
   logic [IDW-1:0] tag_id_reg [LAT+1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= LAT; k++) begin
            tag_v_reg[k]  <= 1'b0;
            tag_id_reg[k] <= '0;
         end
      end else begin
         tag_v_reg[0]  <= accept;
         tag_id_reg[0] <= win_id;
         for (int k = 1; k <= LAT; k++) begin
            tag_v_reg[k]  <= tag_v_reg[k-1];
            tag_id_reg[k] <= tag_id_reg[k-1];
         end
      end
   end

   assign push = tag_v_reg[LAT];

   // ---------------------------------------------------------------
   // Result FIFO (show-ahead)
   // ---------------------------------------------------------------
   logic [PWID-1:0] fifo_p  [DEPTH];
   logic [IDW-1:0]  fifo_id [DEPTH];
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]   fcnt_reg;

   function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_p[wr_ptr_reg]  <= mul_p;
         fifo_id[wr_ptr_reg] <= tag_id_reg[LAT];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         fcnt_reg   <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= inc_ptr(wr_ptr_reg);
         if (pop)
            rd_ptr_reg <= inc_ptr(rd_ptr_reg);
         if (push && !pop)
            fcnt_reg <= fcnt_reg + CW'(1);
         else if (!push && pop)
            fcnt_reg <= fcnt_reg - CW'(1);
      end
   end

   // Head data is masked while empty so the outputs read zero after reset
   // instead of whatever the storage array happens to hold.
   assign rsp_valid = (fcnt_reg != '0);
   assign rsp_p     = rsp_valid ? fifo_p[rd_ptr_reg]  : '0;
   assign rsp_id    = rsp_valid ? fifo_id[rd_ptr_reg] : '0;

   // The credit limit guarantees a free slot for every product.
   no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                 !(push && !pop && (fcnt_reg == CW'(DEPTH))));

endmodule

// File: tb/tb_mulsgn_arbiter.sv
module tb_mulsgn_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

`ifdef MULSGN_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   // ---------------- main DUT: NREQ=4, 8x8, LAT=2 ----------------
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_x, req_y;
   logic [3:0]  req_ready;
   logic [7:0]  mul_x, mul_y;
   logic [15:0] mul_p;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_p;
   logic [1:0]  rsp_id;
   logic        busy;

   mulsgn_arbiter #(.NREQ(4), .widthX(8), .widthY(8), .LAT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
      .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p), .rsp_id(rsp_id),
      .busy(busy)
   );

   // ---------------- second DUT: LAT=0 ----------------
   logic [3:0]  req_valid_z;
   logic [31:0] req_x_z, req_y_z;
   logic [3:0]  req_ready_z;
   logic [7:0]  mul_x_z, mul_y_z;
   logic [15:0] mul_p_z;
   logic        rsp_valid_z, rsp_ready_z;
   logic [15:0] rsp_p_z;
   logic [1:0]  rsp_id_z;
   logic        busy_z;

   mulsgn_arbiter #(.NREQ(4), .widthX(8), .widthY(8), .LAT(0)) dut_z (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid_z), .req_x(req_x_z), .req_y(req_y_z), .req_ready(req_ready_z),
      .mul_x(mul_x_z), .mul_y(mul_y_z), .mul_p(mul_p_z),
      .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_p(rsp_p_z), .rsp_id(rsp_id_z),
      .busy(busy_z)
   );

   function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
      logic signed [15:0] ea, eb;
      ea = {{8{a[7]}}, a};
      eb = {{8{b[7]}}, b};
      return 16'(ea * eb);
   endfunction

   // Multiplier models: two register stages for LAT=2, combinational for LAT=0
   logic [15:0] p_d1, p_d2;
   always @(posedge clk) begin
      p_d1 <= smul(mul_x, mul_y);
      p_d2 <= p_d1;
   end
   assign mul_p   = p_d2;
   assign mul_p_z = smul(mul_x_z, mul_y_z);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: records accepts, checks every response handshake in order
   logic [17:0] sb [$];
   always @(negedge clk) begin
      logic [17:0] e;
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'(rsp_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               check("sb_p", 32'(rsp_p), 32'(e[15:0]));
               check("sb_id", 32'(rsp_id), 32'(e[17:16]));
               $display("rsp id=%0d p=%h", rsp_id, rsp_p);
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i])
               sb.push_back({2'(i), smul(req_x[i*8 +: 8], req_y[i*8 +: 8])});
         end
      end
   end

   logic [7:0] bx [6];
   logic [7:0] by [6];

   initial begin
      bx[0] = 8'h80; by[0] = 8'h80;   // 16384
      bx[1] = 8'h80; by[1] = 8'h7F;   // -16256
      bx[2] = 8'h00; by[2] = 8'h55;   // 0
      bx[3] = 8'h7F; by[3] = 8'h7F;   // 16129
      bx[4] = 8'hFF; by[4] = 8'h01;   // -1
      bx[5] = 8'h02; by[5] = 8'hFB;   // -10

      rst_n = 1'b0;
      req_valid = '0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
      req_valid_z = '0; req_x_z = '0; req_y_z = '0; rsp_ready_z = 1'b0;

      // ---------------- reset state ----------------
      #3;
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_mul_x", 32'(mul_x), 32'h0);
      check("rst_mul_y", 32'(mul_y), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_p", 32'(rsp_p), 32'h0);
      check("rst_rsp_id", 32'(rsp_id), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      #10;
      rst_n = 1'b1;
      tick();

      // ---------------- single request: -3 * 7 from requester 2 ----------------
      req_x[23:16] = 8'hFD; req_y[23:16] = 8'h07; req_valid = 4'b0100;
      #1;
      check("p1_grant", 32'(req_ready), 32'h4);
      check("p1_busy_idle", 32'(busy), 32'h0);
      tick();
      req_valid = 4'b0000;
      check("p1_mul_x", 32'(mul_x), 32'hFD);
      check("p1_mul_y", 32'(mul_y), 32'h07);
      check("p1_busy", 32'(busy), 32'h1);
      check("p1_valid_t0", 32'(rsp_valid), 32'h0);
      tick();
      check("p1_valid_t1", 32'(rsp_valid), 32'h0);
      check("p1_mul_x_hold", 32'(mul_x), 32'hFD);
      tick();
      check("p1_valid_t2", 32'(rsp_valid), 32'h0);
      tick();
      check("p1_valid_t3", 32'(rsp_valid), 32'h1);
      check("p1_rsp_p", 32'(rsp_p), 32'hFFEB);
      check("p1_rsp_id", 32'(rsp_id), 32'h2);
      rsp_ready = 1'b1;
      #1;
      check("p1_busy_before_hs", 32'(busy), 32'h1);
      tick();
      check("p1_busy_after_hs", 32'(busy), 32'h0);
      check("p1_valid_after_hs", 32'(rsp_valid), 32'h0);

      // fresh reset so the round-robin pointer starts at 0
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();

      // ---------------- sustained throughput, all four valid ----------------
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_x[i*8 +: 8] = 8'(3*i + 1);
         req_y[i*8 +: 8] = 8'(240 + i);
      end
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("p2_grant", 32'(req_ready), RR ? (32'h1 << (k % 4)) : 32'h1);
         $display("p2 cycle %0d grant=%b", k, req_ready);
         tick();
      end
      req_valid = 4'b0000;
      repeat (6) tick();
      check("p2_drained", 32'(sb.size()), 32'h0);
      check("p2_busy", 32'(busy), 32'h0);

      // ---------------- backpressure with corner operands ----------------
      rsp_ready = 1'b0;
      req_x[31:24] = bx[0]; req_y[31:24] = by[0];
      req_valid = 4'b1000;
      begin
         int k;
         k = 0;
         for (int c = 0; c < 7; c++) begin
            #1;
            check("p3_grant", 32'(req_ready), (c < 5) ? 32'h8 : 32'h0);
            tick();
            if (c < 5) begin
               k++;
               req_x[31:24] = bx[k]; req_y[31:24] = by[k];
            end
         end
      end
      repeat (2) tick();
      check("p3_full_busy", 32'(busy), 32'h1);
      check("p3_full_valid", 32'(rsp_valid), 32'h1);
      check("p3_head0_p", 32'(rsp_p), 32'h4000);
      check("p3_head0_id", 32'(rsp_id), 32'h3);
      rsp_ready = 1'b1;
      #1;
      check("p3_no_comb_path", 32'(req_ready), 32'h0);
      tick();
      rsp_ready = 1'b0;
      check("p3_head1_p", 32'(rsp_p), 32'hC080);
      #1;
      check("p3_regrant", 32'(req_ready), 32'h8);
      tick();
      req_valid = 4'b0000;
      check("p3_refill_mul_x", 32'(mul_x), 32'h02);
      tick();
      tick();
      rsp_ready = 1'b1;   // push and pop together at occupancy DEPTH-1
      tick();
      check("p3_pushpop_valid", 32'(rsp_valid), 32'h1);
      check("p3_head2_p", 32'(rsp_p), 32'h0000);
      check("p3_head2_id", 32'(rsp_id), 32'h3);
      repeat (6) tick();
      check("p3_drained", 32'(sb.size()), 32'h0);
      check("p3_busy", 32'(busy), 32'h0);
      check("p3_valid", 32'(rsp_valid), 32'h0);

      // ---------------- asynchronous reset with 3 in flight ----------------
      rsp_ready = 1'b0;
      req_x[15:8]  = 8'h11; req_y[15:8]  = 8'h03;
      req_x[23:16] = 8'h22; req_y[23:16] = 8'h05;
      req_valid = 4'b0110;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("p5_grant", 32'(req_ready), (RR && c == 1) ? 32'h4 : 32'h2);
         tick();
      end
      req_x[7:0] = 8'h09; req_y[7:0] = 8'h09;
      req_valid = 4'b0101;
      #1;
      rst_n = 1'b0;
      #1;
      check("p5_rst_req_ready", 32'(req_ready), 32'h0);
      check("p5_rst_mul_x", 32'(mul_x), 32'h0);
      check("p5_rst_mul_y", 32'(mul_y), 32'h0);
      check("p5_rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("p5_rst_rsp_p", 32'(rsp_p), 32'h0);
      check("p5_rst_rsp_id", 32'(rsp_id), 32'h0);
      check("p5_rst_busy", 32'(busy), 32'h0);
      repeat (3) tick();
      check("p5_in_rst_valid", 32'(rsp_valid), 32'h0);
      req_valid = 4'b0000;
      rsp_ready = 1'b1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("p5_no_stale_valid", 32'(rsp_valid), 32'h0);
         check("p5_no_stale_busy", 32'(busy), 32'h0);
      end
      req_valid = 4'b0101;
      #1;
      check("p5_first_grant", 32'(req_ready), 32'h1);
      tick();
      #1;
      check("p5_second_grant", 32'(req_ready), RR ? 32'h4 : 32'h1);
      tick();
      req_valid = 4'b0000;
      repeat (6) tick();
      check("p5_drained", 32'(sb.size()), 32'h0);
      check("p5_busy", 32'(busy), 32'h0);

      // ---------------- LAT=0 instance: 5 * -3 from requester 1 ----------------
      req_x_z[15:8] = 8'h05; req_y_z[15:8] = 8'hFD;
      req_valid_z = 4'b0010;
      rsp_ready_z = 1'b1;
      #1;
      check("z_grant0", 32'(req_ready_z), 32'h2);
      tick();
      check("z_valid_t0", 32'(rsp_valid_z), 32'h0);
      for (int c = 0; c < 6; c++) begin
         #1;
         check("z_grant", 32'(req_ready_z), 32'h2);
         tick();
         check("z_valid", 32'(rsp_valid_z), 32'h1);
         check("z_rsp_p", 32'(rsp_p_z), 32'hFFF1);
         check("z_rsp_id", 32'(rsp_id_z), 32'h1);
      end
      req_valid_z = 4'b0000;
      repeat (3) tick();
      check("z_busy", 32'(busy_z), 32'h0);
      check("z_valid_end", 32'(rsp_valid_z), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
